date_operation: RTL and testbench
=================================

# date_operation

Calendar stage directly downstream of the time-of-day counters: consumes the end-of-day carry (`cout_day`) and maintains day, month and year for the display module. It covers years 2000–2099 (stored as a 0–99 offset) with leap-year handling. The stage supports a synchronous date-set path that mirrors the time-set path. All state is clocked on the single system clock; the incoming carry is synchronized and edge-detected, never used as a clock.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `cout_day`. Legal values are 2 or 3.
- `RESET_YEAR`, default 0: year offset loaded at reset (2000 + value).

Ports:
- `clk`, input, 1 bit: system clock.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `cout_day`, input, 1 bit: end-of-day carry from the hour counter. It is a level; a 0→1 transition means one day has elapsed.
- `set_date_en`, input, 1 bit: while high, load set values every cycle.
- `set_date_day`, input, 5 bits: day of month, 1–31.
- `set_date_month`, input, 4 bits: month, 1–12.
- `set_date_year`, input, 7 bits: year offset, 0–99.
- `out_day`, output, 5 bits: current day, 1–31.
- `out_month`, output, 4 bits: current month, 1–12.
- `out_year`, output, 7 bits: current year offset, 0–99.
- `cout_century`, output, 1 bit: one-cycle pulse on the wrap from 99-12-31 to 00-01-01.

## Operation
- **Reset** (asynchronous, `rst_n` low):
  - `out_day`=1, `out_month`=1, `out_year`=`RESET_YEAR`, `cout_century`=0.
  - Synchronizer and edge flops are cleared to 0.
- **Day tick:** `tick` = synchronized `cout_day` AND NOT its previous sample. `tick` is high for exactly one clk cycle per rising edge.
- **Month length:** `days_in_month(month, year)` returns:
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - 29 for month 2 when `year[1:0]==0` (year 2000 is a leap year).
  - 28 for month 2 otherwise.
- **On `tick` with `set_date_en` low:**
  - If day < `days_in_month`: day+1.
  - Else day=1, and:
    - if month < 12: month+1;
    - else month=1 and year+1; if year was 99, year=0 and `cout_century` pulses.
- **Set path (`set_date_en` high):**
  - Registers load the set values every cycle. `tick` is ignored and lost.
  - Out-of-range month: 0 loads 1; values above 12 load 12.
  - Out-of-range year: values above 99 load 99.
  - Day 0 loads 1. A day above `days_in_month(clamped month, clamped year)` loads that maximum, e.g. set 2001-02-30 loads 2001-02-28.
- **Invariant:** outputs never hold an invalid date, because the only load paths are reset, increment and the clamped set.

## Timing
- **Synchronizer latency:** `cout_day` sampled high at clk edge N gives `tick` high during the cycle after edge N+`SYNC_STAGES`−1.
  - Outputs update at edge N+`SYNC_STAGES`; with the default that is 2 edges after first sampling.
- **`cout_century`:** registered; high for the single cycle following the edge that stores year 0 from 99.
- **Set load:** set values appear on the outputs one edge after `set_date_en` is sampled high. They hold when `set_date_en` drops.
- **Simultaneous tick and set:** set wins. No increment is applied and no `cout_century` pulse is generated.
- **`cout_day` held high:** produces exactly one tick. A new tick requires `cout_day` to return low for at least one synchronized sample.
- **Reset mid-tick:** a pending tick in the synchronizer is discarded; no increment occurs after reset release unless a fresh 0→1 edge arrives.

## Structure
- **Package `date_pkg`:**
  - Width constants: `DAY_W`=5, `MON_W`=4, `YEAR_W`=7.
  - `MAX_YEAR`=99.
  - Pure function `days_in_month`.
  - Function `clamp_date`, shared by the set path and by the bench reference model.
- **Sub-module `day_carry_sync`:** `SYNC_STAGES` flop chain plus rising-edge detector; outputs `tick`. Reused by any later block that consumes a ripple carry.
- **Top:** one `always_ff` for day/month/year/`cout_century` with priority order reset > set > tick.

## Test plan
- **Reset:** assert `rst_n` low mid-run → outputs 01/01/`RESET_YEAR`; `cout_century`=0 asynchronously, without waiting for a clk edge.
- **Month rollovers:** set 2023-01-31, pulse `cout_day` → 2023-02-01. Then set 2023-04-30 and pulse → 2023-05-01. Check the update lands exactly `SYNC_STAGES` edges after first high sample.
- **Leap year:** set 2024-02-28, two ticks → 2024-02-29 then 2024-03-01. Set 2023-02-28, one tick → 2023-03-01.
- **Century wrap:** set 2099-12-31, tick → 2000-01-01 (offset 0). `cout_century` high for exactly 1 cycle.
- **Set clamping:**
  - set day=30, month=2, year=1 → 2001-02-28;
  - set month=15, day=0, year=120 → 2099-12-01.
- **Edge cases:**
  - `cout_day` held high for 10 cycles → exactly one increment;
  - tick coincident with `set_date_en` → set value loaded, no increment.
- **Coverage:** random 5000-day run against the `date_pkg` model; no mismatches allowed.

Source files
------------

// File: rtl/date_pkg.sv
// Shared calendar definitions: field widths, the date record, month length and
// the clamping used when a date is loaded from the set inputs.
package date_pkg;

   localparam int DAY_W    = 5;
   localparam int MON_W    = 4;
   localparam int YEAR_W   = 7;
   localparam int MAX_YEAR = 99;

   typedef struct packed {
      logic [YEAR_W-1:0] year;
      logic [MON_W-1:0]  month;
      logic [DAY_W-1:0]  day;
   } date_t;

   // Number of days in a month; every year divisible by four is a leap year
   // inside 2000-2099, so only the two low bits of the offset matter.
   function automatic logic [DAY_W-1:0] days_in_month(
      input logic [MON_W-1:0]  month,
      input logic [YEAR_W-1:0] year
   );
      logic [DAY_W-1:0] n;
      case (month)
         MON_W'(4), MON_W'(6), MON_W'(9), MON_W'(11): n = DAY_W'(30);
         MON_W'(2): n = (year[1:0] == 2'b00) ? DAY_W'(29) : DAY_W'(28);
         default:   n = DAY_W'(31);
      endcase
      return n;
   endfunction

   // Forces arbitrary set inputs onto a valid date. Month and year are
   // clamped first because the legal day range depends on both.
   function automatic date_t clamp_date(
      input logic [DAY_W-1:0]  day,
      input logic [MON_W-1:0]  month,
      input logic [YEAR_W-1:0] year
   );
      date_t            r;
      logic [DAY_W-1:0] dmax;
      if (month == '0)
         r.month = MON_W'(1);
      else if (month > MON_W'(12))
         r.month = MON_W'(12);
      else
         r.month = month;
      r.year = (year > YEAR_W'(MAX_YEAR)) ? YEAR_W'(MAX_YEAR) : year;
      dmax   = days_in_month(r.month, r.year);
      if (day == '0)
         r.day = DAY_W'(1);
      else if (day > dmax)
         r.day = dmax;
      else
         r.day = day;
      return r;
   endfunction

endpackage

// File: rtl/date_operation_if.sv
// Bundle of the calendar stage's carry input, set path and date outputs.
interface date_operation_if;
   import date_pkg::*;

   logic              cout_day;
   logic              set_date_en;
   logic [DAY_W-1:0]  set_date_day;
   logic [MON_W-1:0]  set_date_month;
   logic [YEAR_W-1:0] set_date_year;
   logic [DAY_W-1:0]  out_day;
   logic [MON_W-1:0]  out_month;
   logic [YEAR_W-1:0] out_year;
   logic              cout_century;

   // Driver side: time-of-day counters and the set controller
   modport master (
      output cout_day, set_date_en, set_date_day, set_date_month, set_date_year,
      input  out_day, out_month, out_year, cout_century
   );

   // Calendar stage side
   modport slave (
      input  cout_day, set_date_en, set_date_day, set_date_month, set_date_year,
      output out_day, out_month, out_year, cout_century
   );
endinterface

// File: rtl/day_carry_sync.sv
// Synchronizes a ripple-carry level into this clock domain and emits a
// single-cycle tick on each rising edge of the synchronized level.
module day_carry_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic carry_i,
   output logic tick_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Flop chain plus one history flop for edge detection; reset discards any
   // carry edge still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], carry_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign tick_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/date_operation.sv
// Calendar stage: advances day/month/year on each end-of-day carry, with a
// clamped synchronous set path that takes priority over the carry.
module date_operation
   import date_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int RESET_YEAR  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   date_operation_if.slave  bus
);

   logic [DAY_W-1:0]  day_q,   day_d;
   logic [MON_W-1:0]  month_q, month_d;
   logic [YEAR_W-1:0] year_q,  year_d;
   logic              century_q, century_d;
   logic              tick;
   date_t             set_clamped;

   day_carry_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .carry_i (bus.cout_day),
      .tick_o  (tick)
   );

   assign set_clamped = clamp_date(bus.set_date_day, bus.set_date_month, bus.set_date_year);

   // Next date: set overrides the tick (the tick is simply dropped), otherwise
   // ripple day -> month -> year, flagging the 99 -> 00 wrap.
   always_comb begin
      day_d     = day_q;
      month_d   = month_q;
      year_d    = year_q;
      century_d = 1'b0;
      if (bus.set_date_en) begin
         day_d   = set_clamped.day;
         month_d = set_clamped.month;
         year_d  = set_clamped.year;
      end else if (tick) begin
         if (day_q < days_in_month(month_q, year_q)) begin
            day_d = day_q + DAY_W'(1);
         end else begin
            day_d = DAY_W'(1);
            if (month_q < MON_W'(12)) begin
               month_d = month_q + MON_W'(1);
            end else begin
               month_d = MON_W'(1);
               if (year_q == YEAR_W'(MAX_YEAR)) begin
                  year_d    = '0;
                  century_d = 1'b1;
               end else begin
                  year_d = year_q + YEAR_W'(1);
               end
            end
         end
      end
   end

   // Date and century-pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         day_q     <= DAY_W'(1);
         month_q   <= MON_W'(1);
         year_q    <= YEAR_W'(RESET_YEAR);
         century_q <= 1'b0;
      end else begin
         day_q     <= day_d;
         month_q   <= month_d;
         year_q    <= year_d;
         century_q <= century_d;
      end
   end

   assign bus.out_day      = day_q;
   assign bus.out_month    = month_q;
   assign bus.out_year     = year_q;
   assign bus.cout_century = century_q;

endmodule

// File: tb/tb_date_operation.sv
// Directed bench for date_operation: reset, rollovers, leap years, century
// wrap, set clamping, carry edge cases and a long run against a table model.
module tb_date_operation;

   localparam int S      = 2;
   localparam int RST_YR = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   date_operation_if b();

   date_operation #(
      .SYNC_STAGES (S),
      .RESET_YEAR  (RST_YR)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_date(input string tag, input int d, input int m, input int y);
      check({tag, ".day"},   int'(b.out_day),   d);
      check({tag, ".month"}, int'(b.out_month), m);
      check({tag, ".year"},  int'(b.out_year),  y);
   endtask

   task automatic set_date(input int d, input int m, input int y);
      @(negedge clk);
      b.set_date_en    = 1'b1;
      b.set_date_day   = 5'(d);
      b.set_date_month = 4'(m);
      b.set_date_year  = 7'(y);
      @(negedge clk);
      b.set_date_en    = 1'b0;
   endtask

   task automatic pulse_day();
      @(negedge clk);
      b.cout_day = 1'b1;
      repeat (S + 1) @(negedge clk);
      b.cout_day = 1'b0;
      repeat (S + 1) @(negedge clk);
   endtask

   function automatic int model_mdays(input int m, input int y);
      int tbl [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      if (m == 2 && (y % 4) == 0) return 29;
      return tbl[m-1];
   endfunction

   initial begin
      int cnt;
      int md, mm, my;
      b.cout_day       = 1'b0;
      b.set_date_en    = 1'b0;
      b.set_date_day   = '0;
      b.set_date_month = '0;
      b.set_date_year  = '0;

      // Power-on reset
      #23;
      check_date("reset_init", 1, 1, RST_YR);
      check("reset_init.century", int'(b.cout_century), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_date("after_release", 1, 1, RST_YR);

      // Month rollover with exact latency check
      set_date(31, 1, 23);
      check_date("set_jan31", 31, 1, 23);
      @(negedge clk);
      b.cout_day = 1'b1;
      for (int k = 0; k < S; k++) begin
         @(negedge clk);
         check("lat_hold.day", int'(b.out_day), 31);
      end
      @(negedge clk);
      check_date("jan31_tick", 1, 2, 23);
      b.cout_day = 1'b0;
      repeat (S + 1) @(negedge clk);
      $display("[TB] rollover 2023-01-31 -> %0d-%0d-%0d", b.out_year, b.out_month, b.out_day);

      set_date(30, 4, 23);
      pulse_day();
      check_date("apr30_tick", 1, 5, 23);

      // Leap and non-leap February
      set_date(28, 2, 24);
      pulse_day();
      check_date("leap_feb29", 29, 2, 24);
      pulse_day();
      check_date("leap_mar1", 1, 3, 24);
      set_date(28, 2, 23);
      pulse_day();
      check_date("nonleap_mar1", 1, 3, 23);
      set_date(31, 12, 30);
      pulse_day();
      check_date("year_wrap", 1, 1, 31);

      // Century wrap with single-cycle pulse
      set_date(31, 12, 99);
      @(negedge clk);
      b.cout_day = 1'b1;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (b.cout_century) cnt++;
      end
      check("century.pulses", cnt, 1);
      check_date("century_wrap", 1, 1, 0);
      b.cout_day = 1'b0;
      repeat (S + 1) @(negedge clk);
      check("century.low", int'(b.cout_century), 0);
      $display("[TB] century wrap pulses=%0d", cnt);

      // Set clamping
      set_date(30, 2, 1);
      check_date("clamp_feb30", 28, 2, 1);
      set_date(0, 15, 120);
      check_date("clamp_big", 1, 12, 99);
      set_date(31, 4, 10);
      check_date("clamp_apr31", 30, 4, 10);
      set_date(5, 0, 12);
      check_date("clamp_mon0", 5, 1, 12);

      // Carry held high for ten cycles gives one increment, then re-arms
      set_date(10, 6, 23);
      @(negedge clk);
      b.cout_day = 1'b1;
      repeat (10) @(negedge clk);
      check("held.day", int'(b.out_day), 11);
      b.cout_day = 1'b0;
      repeat (S + 2) @(negedge clk);
      check("held_low.day", int'(b.out_day), 11);
      pulse_day();
      check("rearm.day", int'(b.out_day), 12);

      // Tick coincident with set: set wins, tick is lost
      @(negedge clk);
      b.cout_day = 1'b1;
      repeat (S) @(negedge clk);
      b.set_date_en    = 1'b1;
      b.set_date_day   = 5'd20;
      b.set_date_month = 4'd7;
      b.set_date_year  = 7'd23;
      @(negedge clk);
      b.set_date_en    = 1'b0;
      check_date("coincident", 20, 7, 23);
      repeat (3) @(negedge clk);
      b.cout_day = 1'b0;
      repeat (S + 2) @(negedge clk);
      check_date("coincident_hold", 20, 7, 23);

      // Asynchronous reset mid-cycle
      set_date(5, 5, 50);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_date("async_reset", 1, 1, RST_YR);
      check("async_reset.century", int'(b.cout_century), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset with a carry edge in flight discards it
      set_date(5, 5, 50);
      @(negedge clk);
      b.cout_day = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      b.cout_day = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (S + 4) @(negedge clk);
      check_date("reset_midtick", 1, 1, RST_YR);

      // Long run across the century against a table model
      set_date(27, 2, 96);
      md = 27; mm = 2; my = 96;
      for (int i = 0; i < 5000; i++) begin
         pulse_day();
         if (md < model_mdays(mm, my)) md++;
         else begin
            md = 1;
            if (mm < 12) mm++;
            else begin
               mm = 1;
               my = (my == 99) ? 0 : my + 1;
            end
         end
         check("run.date", int'({b.out_year, b.out_month, b.out_day}),
               (my << 9) | (mm << 5) | md);
      end
      $display("[TB] long run ended at %0d-%0d-%0d", b.out_year, b.out_month, b.out_day);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
